mc_sequencer: RTL and testbench
===============================

Name: mc_sequencer

Overview:
- Multi-cycle control sequencer for the MIPS datapath.
- Steps each instruction through fetch, decode, execute, memory and writeback states, driving the datapath strobes state by state.
- Waits on a single shared memory port using a ready handshake, with timeout.
- Sits between the instruction register and the datapath; replaces single-cycle control decode for the multi-cycle build.

Parameters:
- TIMEOUT, 255: max cycles to wait for mem_ready in any memory state before trapping; 0 disables the timeout.
- CW, 8: width of the wait counter; must satisfy TIMEOUT < 2^CW.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  leave IDLE and begin fetching; sampled in IDLE and HALT
- opcode  in  6  instruction[31:26] from the instruction register, valid from DECODE onward
- funct  in  6  instruction[5:0] from the instruction register
- zero  in  1  ALU zero flag, sampled in BRANCH
- mem_ready  in  1  memory completes the current read/write this cycle
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- iord  out  1  address select: 0 = PC, 1 = ALU result
- ir_write  out  1  load the instruction register
- pc_write  out  1  unconditional PC load
- pc_src  out  2  PC source: 00 = PC+4, 01 = branch target, 10 = jump target, 11 = rs (register)
- reg_write  out  1  register file write enable
- reg_dst  out  1  destination select: 1 = rd, 0 = rt
- mem2reg  out  1  writeback data select: 1 = memory data register
- alu_src_b  out  2  ALU B select: 00 = rt, 01 = const 4, 10 = immediate, 11 = immediate<<2
- alu_op  out  3  000 add, 001 sub, 010 shift/compare, 011 and, 100 or, 101 xor, 110 nor, 111 none
- sign_xtend  out  1  sign-extend the immediate
- busy  out  1  high in every state except IDLE and HALT
- trap  out  1  sticky; set on illegal opcode or memory timeout
- state  out  4  current state encoding, for debug

Behaviour:
- Reset (async, rst_n low): state = IDLE, wait counter = 0, trap = 0. All outputs 0 while in IDLE.
- Reset mid-instruction aborts it immediately; no further strobes are issued.
- State encodings: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM_RD 4, MEM_WR 5, WB_ALU 6, WB_MEM 7, BRANCH 8, JUMP 9, HALT 10.
- IDLE: go to FETCH when run = 1.
- FETCH: mem_read = 1, iord = 0.
  - Hold until mem_ready = 1.
  - In the mem_ready cycle (Mealy): ir_write = 1, pc_write = 1, pc_src = 00, alu_src_b = 01, alu_op = 000; next state DECODE.
- DECODE: alu_src_b = 11, alu_op = 000 (branch target precompute). Classify the opcode:
  - 000000 with funct 001xxx -> JUMP with pc_src = 11 (JR).
  - 000000 otherwise -> EXEC.
  - 00001x -> JUMP with pc_src = 10.
  - 0001xx -> BRANCH.
  - 001xxx, 100xxx, 101xxx -> EXEC.
  - Anything else -> HALT with trap = 1.
- EXEC:
  - R-type: alu_src_b = 00. alu_op from funct: 10000x -> 000, 10001x -> 001, 000xxx or 1010xx -> 010, 100100 -> 011, 100101 -> 100, 100110 -> 101, 100111 -> 110, else 111. sign_xtend = ~funct[0]. Next WB_ALU.
  - I-type ALU (001xxx): alu_src_b = 10. alu_op: 00100x -> 000, 00101x -> 010, 001100 -> 011, 001101 -> 100, 001110 -> 101, 001111 -> 010. sign_xtend = ~opcode[0] for 0010xx, 0 for logic ops. Next WB_ALU.
  - Load/store: alu_src_b = 10, alu_op = 000, sign_xtend = 1. Next MEM_RD for loads, MEM_WR for stores.
- MEM_RD: mem_read = 1, iord = 1. Hold until mem_ready, then WB_MEM.
- MEM_WR: mem_write = 1, iord = 1. Hold until mem_ready, then FETCH.
- WB_ALU: reg_write = 1, reg_dst = (opcode == 0). Next FETCH.
- WB_MEM: reg_write = 1, reg_dst = 0, mem2reg = 1. Next FETCH.
- BRANCH: alu_src_b = 00, alu_op = 001.
  - pc_write = 1 with pc_src = 01 when the branch is taken: opcode[0] = 0 (beq) and zero = 1, or opcode[0] = 1 (bne) and zero = 0.
  - Next FETCH.
- JUMP: pc_write = 1 with the latched pc_src. Next FETCH.
- Memory wait timeout:
  - Wait counter clears on entry to FETCH, MEM_RD and MEM_WR; increments each cycle mem_ready = 0.
  - If the counter reaches TIMEOUT (TIMEOUT != 0): go to HALT, set trap, drop the request. No ir_write, pc_write or reg_write is issued.
  - mem_ready arriving in the same cycle the counter reaches TIMEOUT counts as success.
- HALT: all strobes 0; trap holds. run = 1 clears trap and goes to FETCH.
- mem_ready outside the memory states is ignored.
- Latency with zero-wait memory: R-type/ALU-imm 4 cycles, load 5, store 4, branch 3, jump 3.

Decomposition:
- Package mc_pkg: opcode class constants (R_TYPE, J, BRANCH, ALUI, LOAD, STORE), state encodings, alu_op codes, pc_src and alu_src_b codes.
- Sub-module mc_alu_decode: combinational opcode/funct -> alu_op and sign_xtend, used in EXEC.

Test Plan:
- Reset, run = 1, mem_ready tied 1, IR = add (000000/100000) -> states 1,2,3,6; reg_write = 1 with reg_dst = 1 in cycle 4; alu_op = 000 in EXEC.
- lw (100011) with mem_ready low for 3 cycles in MEM_RD -> mem_read and iord held 4 cycles; WB_MEM asserts mem2reg = 1 and reg_write = 1; 8 cycles total.
- beq (000100): zero = 1 -> pc_write = 1 with pc_src = 01 in BRANCH. bne (000101) with zero = 1 -> pc_write = 0.
- Opcode 111111 -> HALT, trap = 1, no reg_write. run = 1 -> trap clears, FETCH.
- TIMEOUT = 4, mem_ready never asserted in FETCH -> HALT after 4 wait cycles, ir_write never pulses. Separately, mem_ready on the 4th cycle -> DECODE with no trap.
- rst_n low during MEM_WR -> mem_write drops immediately (async), state = 0; after release, IDLE until run.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and codes for the multi-cycle MIPS control sequencer.
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_MEM_RD = 4'd4,
    S_MEM_WR = 4'd5,
    S_WB_ALU = 4'd6,
    S_WB_MEM = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_HALT   = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    R_TYPE, J, BRANCH, ALUI, LOAD, STORE, ILLEGAL
  } op_class_t;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SHC  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_XOR  = 3'b101;
  localparam logic [2:0] ALU_NOR  = 3'b110;
  localparam logic [2:0] ALU_NONE = 3'b111;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
  localparam logic [1:0] PC_REG = 2'b11;

  localparam logic [1:0] B_RT     = 2'b00;
  localparam logic [1:0] B_FOUR   = 2'b01;
  localparam logic [1:0] B_IMM    = 2'b10;
  localparam logic [1:0] B_IMM_SH = 2'b11;

  // Coarse instruction class from the primary opcode field
  function automatic op_class_t op_class(input logic [5:0] opcode);
    op_class_t c;
    c = ILLEGAL;
    casez (opcode)
      6'b000000: c = R_TYPE;
      6'b00001?: c = J;
      6'b0001??: c = BRANCH;
      6'b001???: c = ALUI;
      6'b100???: c = LOAD;
      6'b101???: c = STORE;
      default:   c = ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational ALU operation and immediate-extension decode for EXEC.
module mc_alu_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       sign_xtend
);

  // Map opcode/funct to ALU function and sign-extension select
  always_comb begin
    alu_op     = ALU_NONE;
    sign_xtend = 1'b0;
    case (op_class(opcode))
      R_TYPE: begin
        sign_xtend = ~funct[0];
        casez (funct)
          6'b10000?:          alu_op = ALU_ADD;
          6'b10001?:          alu_op = ALU_SUB;
          6'b000???, 6'b1010??: alu_op = ALU_SHC;
          6'b100100:          alu_op = ALU_AND;
          6'b100101:          alu_op = ALU_OR;
          6'b100110:          alu_op = ALU_XOR;
          6'b100111:          alu_op = ALU_NOR;
          default:            alu_op = ALU_NONE;
        endcase
      end
      ALUI: begin
        casez (opcode)
          6'b00100?: begin alu_op = ALU_ADD; sign_xtend = ~opcode[0]; end
          6'b00101?: begin alu_op = ALU_SHC; sign_xtend = ~opcode[0]; end
          6'b001100: alu_op = ALU_AND;
          6'b001101: alu_op = ALU_OR;
          6'b001110: alu_op = ALU_XOR;
          default:   alu_op = ALU_SHC;
        endcase
      end
      LOAD, STORE: begin
        alu_op     = ALU_ADD;
        sign_xtend = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer: fetch/decode/execute/memory/writeback FSM
// with a shared ready-handshake memory port and a memory wait timeout.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem2reg,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       sign_xtend,
  output logic       busy,
  output logic       trap,
  output logic [3:0] state
);

  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  state_t    st, st_nx;
  logic      trap_q, trap_nx;
  logic [1:0] jmp_src, jmp_src_nx;
  logic [CW-1:0] wait_cnt;
  logic      mem_state;
  logic      tmo_hit;
  op_class_t cls;
  logic [2:0] dec_alu_op;
  logic      dec_sx;

  mc_alu_decode u_alu_decode (
    .opcode     (opcode),
    .funct      (funct),
    .alu_op     (dec_alu_op),
    .sign_xtend (dec_sx)
  );

  assign cls       = op_class(opcode);
  assign mem_state = (st == S_FETCH) || (st == S_MEM_RD) || (st == S_MEM_WR);
  // ready in the final counted cycle still wins because tmo_hit needs !mem_ready
  assign tmo_hit   = (TIMEOUT != 0) && !mem_ready && (wait_cnt == TMO_LAST);
  assign busy      = (st != S_IDLE) && (st != S_HALT);
  assign trap      = trap_q;
  assign state     = st;

  // State, sticky trap and latched jump source registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= S_IDLE;
      trap_q  <= 1'b0;
      jmp_src <= PC_INC;
    end else begin
      st      <= st_nx;
      trap_q  <= trap_nx;
      jmp_src <= jmp_src_nx;
    end
  end

  // Memory wait counter: cleared on every state change, counts stalled cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wait_cnt <= '0;
    else if (st_nx != st)
      wait_cnt <= '0;
    else if (mem_state && !mem_ready)
      wait_cnt <= wait_cnt + CW'(1);
  end

  // Next-state and per-state datapath strobes
  always_comb begin
    st_nx      = st;
    trap_nx    = trap_q;
    jmp_src_nx = jmp_src;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_INC;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem2reg    = 1'b0;
    alu_src_b  = B_RT;
    alu_op     = ALU_ADD;
    sign_xtend = 1'b0;
    case (st)
      S_IDLE: if (run) st_nx = S_FETCH;
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = B_FOUR;
          st_nx     = S_DECODE;
        end else if (tmo_hit) begin
          st_nx   = S_HALT;
          trap_nx = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_b = B_IMM_SH;
        case (cls)
          R_TYPE: begin
            if (funct[5:3] == 3'b001) begin
              jmp_src_nx = PC_REG;
              st_nx      = S_JUMP;
            end else begin
              st_nx = S_EXEC;
            end
          end
          J: begin
            jmp_src_nx = PC_JMP;
            st_nx      = S_JUMP;
          end
          BRANCH:            st_nx = S_BRANCH;
          ALUI, LOAD, STORE: st_nx = S_EXEC;
          default: begin
            st_nx   = S_HALT;
            trap_nx = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        alu_op     = dec_alu_op;
        sign_xtend = dec_sx;
        alu_src_b  = (cls == R_TYPE) ? B_RT : B_IMM;
        if (cls == LOAD)       st_nx = S_MEM_RD;
        else if (cls == STORE) st_nx = S_MEM_WR;
        else                   st_nx = S_WB_ALU;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) st_nx = S_WB_MEM;
        else if (tmo_hit) begin
          st_nx   = S_HALT;
          trap_nx = 1'b1;
        end
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) st_nx = S_FETCH;
        else if (tmo_hit) begin
          st_nx   = S_HALT;
          trap_nx = 1'b1;
        end
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        reg_dst   = (opcode == 6'b000000);
        st_nx     = S_FETCH;
      end
      S_WB_MEM: begin
        reg_write = 1'b1;
        mem2reg   = 1'b1;
        st_nx     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_b = B_RT;
        alu_op    = ALU_SUB;
        // beq (opcode[0]=0) takes on zero, bne (opcode[0]=1) on non-zero
        if (zero != opcode[0]) begin
          pc_write = 1'b1;
          pc_src   = PC_BR;
        end
        st_nx = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = jmp_src;
        st_nx    = S_FETCH;
      end
      S_HALT: begin
        if (run) begin
          trap_nx = 1'b0;
          st_nx   = S_FETCH;
        end
      end
      default: st_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: instruction-level reference model
// expands each instruction into its expected per-cycle strobe trace.
module tb_mc_sequencer;

  localparam int TMO = 4;
  localparam int C_R = 0, C_ALUI = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_J = 5, C_JR = 6, C_ILL = 7;

  logic clk = 1'b0;
  logic rst_n, run, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic mem_read, mem_write, iord, ir_write, pc_write, reg_write, reg_dst, mem2reg;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;
  logic sign_xtend, busy, trap;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0] st;
    logic mr, mw, io, irw, pcw;
    logic [1:0] pcs;
    logic rw, rd, m2r;
    logic [1:0] asb;
    logic [2:0] aop;
    logic sx, busy, trap;
  } obs_t;

  typedef struct {
    obs_t e;
    logic rdy;
    logic z;
    logic r;
    logic [5:0] op;
    logic [5:0] fn;
  } cyc_t;

  typedef struct {
    string name;
    logic [5:0] op;
    logic [5:0] fn;
    int cls;
    logic [2:0] aop;
    logic sx;
  } ins_t;

  cyc_t q[$];
  ins_t tbl[$];
  obs_t act;

  assign act = {state, mem_read, mem_write, iord, ir_write, pc_write, pc_src,
                reg_write, reg_dst, mem2reg, alu_src_b, alu_op, sign_xtend, busy, trap};

  mc_sequencer #(.TIMEOUT(TMO), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem2reg(mem2reg),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .sign_xtend(sign_xtend),
    .busy(busy), .trap(trap), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic obs_t blank(input logic [3:0] st, input logic bsy, input logic trp);
    obs_t e;
    e = '0;
    e.st = st;
    e.busy = bsy;
    e.trap = trp;
    return e;
  endfunction

  function automatic ins_t find(input string n);
    foreach (tbl[i]) if (tbl[i].name == n) return tbl[i];
    return tbl[0];
  endfunction

  task automatic push(input obs_t e, input logic rdy, input logic z, input logic r,
                      input logic [5:0] op, input logic [5:0] fn);
    cyc_t c;
    c.e = e; c.rdy = rdy; c.z = z; c.r = r; c.op = op; c.fn = fn;
    q.push_back(c);
  endtask

  task automatic push_idle(input logic r);
    push(blank(4'd0, 1'b0, 1'b0), rb(), rb(), r, rop(), rop());
  endtask

  // Trap lands in HALT; holds with run low, then run releases it to FETCH
  task automatic push_halt();
    int n;
    n = 1 + int'($urandom_range(1));
    for (int i = 0; i < n; i++) push(blank(4'd10, 1'b0, 1'b1), rb(), rb(), 1'b0, rop(), rop());
    push(blank(4'd10, 1'b0, 1'b1), rb(), rb(), 1'b1, rop(), rop());
  endtask

  // Stalled cycles in a memory state; flags a timeout once TMO stalls elapse
  task automatic mem_wait(input logic [3:0] st, input int w, input logic [5:0] op,
                          input logic [5:0] fn, input logic ir_ok, output bit to);
    obs_t e;
    to = 1'b0;
    for (int k = 1; k <= w; k++) begin
      e = blank(st, 1'b1, 1'b0);
      e.mr = (st != 4'd5);
      e.mw = (st == 4'd5);
      e.io = (st != 4'd1);
      push(e, 1'b0, rb(), rb(), ir_ok ? op : rop(), ir_ok ? fn : rop());
      if (k == TMO) begin
        to = 1'b1;
        break;
      end
    end
  endtask

  task automatic build(input ins_t I, input int wf, input int wm, input logic z);
    obs_t e;
    bit to;
    logic [5:0] fn;
    logic tk;
    fn = (I.cls == C_R || I.cls == C_JR) ? I.fn : rop();
    mem_wait(4'd1, wf, I.op, fn, 1'b0, to);
    if (to) begin push_halt(); return; end
    e = blank(4'd1, 1'b1, 1'b0);
    e.mr = 1'b1; e.irw = 1'b1; e.pcw = 1'b1; e.asb = 2'b01;
    push(e, 1'b1, rb(), rb(), rop(), rop());
    e = blank(4'd2, 1'b1, 1'b0);
    e.asb = 2'b11;
    push(e, rb(), rb(), rb(), I.op, fn);
    case (I.cls)
      C_R, C_ALUI: begin
        e = blank(4'd3, 1'b1, 1'b0);
        e.asb = (I.cls == C_R) ? 2'b00 : 2'b10; e.aop = I.aop; e.sx = I.sx;
        push(e, rb(), rb(), rb(), I.op, fn);
        e = blank(4'd6, 1'b1, 1'b0);
        e.rw = 1'b1; e.rd = (I.cls == C_R);
        push(e, rb(), rb(), rb(), I.op, fn);
      end
      C_LD, C_ST: begin
        e = blank(4'd3, 1'b1, 1'b0);
        e.asb = 2'b10; e.aop = 3'b000; e.sx = 1'b1;
        push(e, rb(), rb(), rb(), I.op, fn);
        mem_wait((I.cls == C_LD) ? 4'd4 : 4'd5, wm, I.op, fn, 1'b1, to);
        if (to) begin push_halt(); return; end
        e = blank((I.cls == C_LD) ? 4'd4 : 4'd5, 1'b1, 1'b0);
        e.mr = (I.cls == C_LD); e.mw = (I.cls == C_ST); e.io = 1'b1;
        push(e, 1'b1, rb(), rb(), I.op, fn);
        if (I.cls == C_LD) begin
          e = blank(4'd7, 1'b1, 1'b0);
          e.rw = 1'b1; e.m2r = 1'b1;
          push(e, rb(), rb(), rb(), I.op, fn);
        end
      end
      C_BR: begin
        tk = I.op[0] ? !z : z;
        e = blank(4'd8, 1'b1, 1'b0);
        e.asb = 2'b00; e.aop = 3'b001; e.pcw = tk; e.pcs = tk ? 2'b01 : 2'b00;
        push(e, rb(), z, rb(), I.op, fn);
      end
      C_J, C_JR: begin
        e = blank(4'd9, 1'b1, 1'b0);
        e.pcw = 1'b1; e.pcs = (I.cls == C_J) ? 2'b10 : 2'b11;
        push(e, rb(), rb(), rb(), I.op, fn);
      end
      default: push_halt();
    endcase
  endtask

  task automatic play(input string tag, input int max_n);
    int n;
    n = 0;
    while (q.size() > 0 && n < max_n) begin
      cyc_t c;
      c = q.pop_front();
      mem_ready = c.rdy; run = c.r; zero = c.z; opcode = c.op; funct = c.fn;
      @(negedge clk);
      n_checks++;
      if (act !== c.e) begin
        n_fail++;
        $display("FAIL %s cycle %0d: actual state=%0d outputs=%h, required state=%0d outputs=%h",
                 tag, n, act.st, act, c.e.st, c.e);
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic add_ins(input string n, input logic [5:0] op, input logic [5:0] fn,
                         input int cls, input logic [2:0] aop, input logic sx);
    ins_t t;
    t.name = n; t.op = op; t.fn = fn; t.cls = cls; t.aop = aop; t.sx = sx;
    tbl.push_back(t);
  endtask

  task automatic init_table();
    add_ins("add",  6'o00, 6'b100000, C_R, 3'b000, 1'b1);
    add_ins("addu", 6'o00, 6'b100001, C_R, 3'b000, 1'b0);
    add_ins("sub",  6'o00, 6'b100010, C_R, 3'b001, 1'b1);
    add_ins("subu", 6'o00, 6'b100011, C_R, 3'b001, 1'b0);
    add_ins("and",  6'o00, 6'b100100, C_R, 3'b011, 1'b1);
    add_ins("or",   6'o00, 6'b100101, C_R, 3'b100, 1'b0);
    add_ins("xor",  6'o00, 6'b100110, C_R, 3'b101, 1'b1);
    add_ins("nor",  6'o00, 6'b100111, C_R, 3'b110, 1'b0);
    add_ins("sll",  6'o00, 6'b000000, C_R, 3'b010, 1'b1);
    add_ins("srav", 6'o00, 6'b000111, C_R, 3'b010, 1'b0);
    add_ins("slt",  6'o00, 6'b101010, C_R, 3'b010, 1'b1);
    add_ins("sltu", 6'o00, 6'b101011, C_R, 3'b010, 1'b0);
    add_ins("mult", 6'o00, 6'b011000, C_R, 3'b111, 1'b1);
    add_ins("jr",   6'o00, 6'b001000, C_JR, 3'b000, 1'b0);
    add_ins("jalr", 6'o00, 6'b001001, C_JR, 3'b000, 1'b0);
    add_ins("addi", 6'b001000, 6'o00, C_ALUI, 3'b000, 1'b1);
    add_ins("addiu",6'b001001, 6'o00, C_ALUI, 3'b000, 1'b0);
    add_ins("slti", 6'b001010, 6'o00, C_ALUI, 3'b010, 1'b1);
    add_ins("sltiu",6'b001011, 6'o00, C_ALUI, 3'b010, 1'b0);
    add_ins("andi", 6'b001100, 6'o00, C_ALUI, 3'b011, 1'b0);
    add_ins("ori",  6'b001101, 6'o00, C_ALUI, 3'b100, 1'b0);
    add_ins("xori", 6'b001110, 6'o00, C_ALUI, 3'b101, 1'b0);
    add_ins("lui",  6'b001111, 6'o00, C_ALUI, 3'b010, 1'b0);
    add_ins("lw",   6'b100011, 6'o00, C_LD, 3'b000, 1'b1);
    add_ins("lb",   6'b100000, 6'o00, C_LD, 3'b000, 1'b1);
    add_ins("sw",   6'b101011, 6'o00, C_ST, 3'b000, 1'b1);
    add_ins("sb",   6'b101000, 6'o00, C_ST, 3'b000, 1'b1);
    add_ins("beq",  6'b000100, 6'o00, C_BR, 3'b001, 1'b0);
    add_ins("bne",  6'b000101, 6'o00, C_BR, 3'b001, 1'b0);
    add_ins("blez", 6'b000110, 6'o00, C_BR, 3'b001, 1'b0);
    add_ins("j",    6'b000010, 6'o00, C_J, 3'b000, 1'b0);
    add_ins("jal",  6'b000011, 6'o00, C_J, 3'b000, 1'b0);
    add_ins("ill3f",6'b111111, 6'o00, C_ILL, 3'b000, 1'b0);
    add_ins("ill10",6'b010000, 6'o00, C_ILL, 3'b000, 1'b0);
    add_ins("ill30",6'b110000, 6'o00, C_ILL, 3'b000, 1'b0);
  endtask

  function automatic int pickw();
    int r;
    r = int'($urandom_range(9));
    if (r < 5) return 0;
    if (r < 9) return int'($urandom_range(3, 1));
    return int'($urandom_range(5, 4));
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = '0; funct = '0;
    #12;
    n_checks++;
    if (act !== blank(4'd0, 1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL reset_state: actual=%h required=%h", act, blank(4'd0, 1'b0, 1'b0));
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    push_idle(1'b0); push_idle(1'b0); push_idle(1'b1);
    play("reset_idle", 100);
  endtask

  task automatic test_rtype();
    build(find("add"), 0, 0, 1'b0);
    play("rtype_add", 100);
  endtask

  task automatic test_load_wait();
    build(find("lw"), 0, 3, 1'b0);
    play("load_wait", 100);
  endtask

  task automatic test_branch();
    build(find("beq"), 0, 0, 1'b1); play("beq_taken", 100);
    build(find("bne"), 0, 0, 1'b1); play("bne_not_taken", 100);
    build(find("beq"), 1, 0, 1'b0); play("beq_not_taken", 100);
    build(find("bne"), 0, 0, 1'b0); play("bne_taken", 100);
  endtask

  task automatic test_illegal();
    build(find("ill3f"), 0, 0, 1'b0);
    play("illegal_op", 100);
  endtask

  task automatic test_timeout();
    build(find("add"), 5, 0, 1'b0); play("fetch_timeout", 100);
    build(find("add"), 3, 0, 1'b0); play("fetch_late_ready", 100);
    build(find("lw"), 0, 4, 1'b0);  play("memrd_timeout", 100);
    build(find("sw"), 2, 3, 1'b0);  play("memwr_late_ready", 100);
    build(find("sw"), 0, 6, 1'b0);  play("memwr_timeout", 100);
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      build(tbl[$urandom_range(tbl.size() - 1)], pickw(), pickw(), rb());
      play("random", 100);
    end
  endtask

  task automatic test_async_reset();
    build(find("sw"), 0, 3, 1'b0);
    play("async_pre", 4);
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if (mem_write !== 1'b1 || state !== 4'd5) begin
      n_fail++;
      $display("FAIL async_in_memwr: actual state=%0d mem_write=%b required state=5 mem_write=1", state, mem_write);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (act !== blank(4'd0, 1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL async_reset_drop: actual=%h required=%h", act, blank(4'd0, 1'b0, 1'b0));
    end
    q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    push_idle(1'b0); push_idle(1'b0); push_idle(1'b0); push_idle(1'b1);
    build(find("or"), 0, 0, 1'b0);
    play("after_async", 100);
  endtask

  initial begin
    init_table();
    test_reset();
    test_rtype();
    test_load_wait();
    test_branch();
    test_illegal();
    test_timeout();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
